sel_pipe_reg: RTL and testbench

Parametrised N-way operand selector with a registered valid/ready output stage, replacing the combinational 2:1/3:1 selectors on the forwarding and writeback paths of the 5-stage core. Picks one of `NSRC` `WIDTH`-bit sources and flags out-of-range selects. The result passes through a 2-entry skid buffer, so stalls from the downstream stage never lose or duplicate data. A flush input squashes in-flight entries on branch redirect.

---
 rtl/sel_pipe_pkg.sv | 16 +
 rtl/sel_pipe_reg_skid_buf.sv | 111 +++++++++++
 rtl/sel_pipe_reg.sv | 60 ++++++
 tb/tb_sel_pipe_reg.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sel_pipe_pkg.sv
// Shared types and helpers for the operand selector pipeline register.
package sel_pipe_pkg;

    // Occupancy of the two-entry output stage, decoded from its valid bits.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // True when a select value addresses one of the nsrc existing sources.
    function automatic logic sel_in_range(input int unsigned sel, input int unsigned nsrc);
        return sel < nsrc;
    endfunction

endpackage

// File: rtl/sel_pipe_reg_skid_buf.sv
// Generic two-entry valid/ready skid buffer. The main register drives the
// outputs directly; the skid register absorbs the one entry that arrives in
// the cycle the consumer stalls, so in_ready never depends on out_ready.
module skid_buf
    import sel_pipe_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic         main_vld_q, main_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] main_data_q;
    logic [W-1:0] skid_data_q;
    logic         load_main;
    logic         load_skid;
    logic         skid_to_main;
    logic         in_xfer;
    logic         out_xfer;
    state_e       cur_state;

    assign in_ready_o  = !skid_vld_q;
    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_data_q;
    assign in_xfer     = in_valid_i && !skid_vld_q;
    assign out_xfer    = main_vld_q && out_ready_i;

    // Decode occupancy from the valid bits (skid valid implies main valid).
    always_comb begin
        cur_state = EMPTY;
        if (main_vld_q) begin
            cur_state = skid_vld_q ? TWO : ONE;
        end
    end

    // Next-state and register load enables; flush drops everything in flight.
    always_comb begin
        main_vld_d   = main_vld_q;
        skid_vld_d   = skid_vld_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            case (cur_state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_vld_d = 1'b1;
                        load_main  = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (in_xfer) begin
                        skid_vld_d = 1'b1;
                        load_skid  = 1'b1;
                    end else if (out_xfer) begin
                        main_vld_d = 1'b0;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        skid_vld_d   = 1'b0;
                        skid_to_main = 1'b1;
                    end
                end
                default: begin
                    main_vld_d = main_vld_q;
                    skid_vld_d = skid_vld_q;
                end
            endcase
        end
    end

    // Valid bits and the output-facing main data; reset clears the visible outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            main_data_q <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            if (load_main) begin
                main_data_q <= in_data_i;
            end else if (skid_to_main) begin
                main_data_q <= skid_data_q;
            end
        end
    end

    // Skid data is only meaningful while its valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data_q <= in_data_i;
        end
    end

endmodule

// File: rtl/sel_pipe_reg.sv
// N-way operand selector with range check, followed by a registered
// valid/ready output stage that tolerates downstream stalls and flushes.
module sel_pipe_reg
    import sel_pipe_pkg::*;
#(
    parameter int                WIDTH       = 32,
    parameter int                NSRC        = 3,
    parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0,
    localparam int               SELW        = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NSRC*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]       in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic [WIDTH:0]   buf_out;

    // Pick the addressed source; an index past the last source yields the default and an error flag.
    always_comb begin
        sel_data = DEFAULT_VAL;
        sel_err  = 1'b1;
        if (sel_in_range(32'(in_sel), NSRC)) begin
            sel_err  = 1'b0;
            sel_data = '0;
            for (int k = 0; k < NSRC; k++) begin
                if (in_sel == SELW'(k)) begin
                    sel_data = in_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    skid_buf #(
        .W (WIDTH + 1)
    ) u_skid_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_data_i   ({sel_err, sel_data}),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (buf_out),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    assign out_err  = buf_out[WIDTH];
    assign out_data = buf_out[WIDTH-1:0];

endmodule

// File: tb/tb_sel_pipe_reg.sv
// Self-checking bench for sel_pipe_reg: directed scenarios plus a randomised
// run against a queue-based reference model of a two-deep FIFO stage.
module tb_sel_pipe_reg;

    logic        clk;
    logic        rst;
    logic [95:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] out_data;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;

    int n_chk;
    int n_fail;

    sel_pipe_reg #(
        .WIDTH       (32),
        .NSRC        (3),
        .DEFAULT_VAL (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Head entry must hold while the consumer stalls.
    assert property (@(posedge clk)
        (!rst && !flush && out_valid && !out_ready) |=>
            (out_valid && $stable(out_data) && $stable(out_err)))
    else begin
        n_fail++;
        $display("FAIL stability: head entry changed while stalled (data=%h err=%b valid=%b)",
                 out_data, out_err, out_valid);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {err, data} for a select, from the selection rules.
    function automatic logic [32:0] ref_entry(input logic [95:0] d, input logic [1:0] s);
        int si;
        si = int'(s);
        if (si < 3) return {1'b0, d[si*32 +: 32]};
        return {1'b1, 32'hDEADBEEF};
    endfunction

    task automatic drain();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sel = 2'd0; in_data = '0;
        step(); step();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_chk++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", out_err); end
        n_chk++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_pass_through();
        in_data = {32'h33333333, 32'h22222222, 32'h11111111};
        in_sel = 2'd2; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid_t1: got %b want 1", out_valid); end
        n_chk++; if (out_data !== 32'h33333333) begin n_fail++; $display("FAIL pass_data: got %h want 33333333", out_data); end
        n_chk++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL pass_err: got %b want 0", out_err); end
        step();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pass_valid_t2: got %b want 0", out_valid); end
    endtask

    task automatic test_out_of_range();
        in_sel = 2'd3; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL oor_valid: got %b want 1", out_valid); end
        n_chk++; if (out_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL oor_data: got %h want deadbeef", out_data); end
        n_chk++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", out_err); end
        step();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL oor_valid_after: got %b want 0", out_valid); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] vals [4];
        logic [31:0] got [$];
        int idx;
        logic acc;
        vals[0] = 32'hAAAA0001; vals[1] = 32'hBBBB0002;
        vals[2] = 32'hCCCC0003; vals[3] = 32'hDDDD0004;
        idx = 0;
        in_sel = 2'd0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = !(cyc >= 1 && cyc <= 3);
            in_valid = (idx < 4);
            if (idx < 4) in_data = {64'h0, vals[idx]};
            else in_data = '0;
            if (cyc == 2 || cyc == 3) begin
                n_chk++; if (idx !== 2 || in_ready !== 1'b0) begin n_fail++;
                    $display("FAIL bp_hold_c: cyc %0d idx %0d in_ready %b want idx 2 in_ready 0", cyc, idx, in_ready); end
            end
            if (out_valid && out_ready) got.push_back(out_data);
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
            if (cyc == 1) begin
                n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_fall: got %b want 0", in_ready); end
            end
        end
        in_valid = 1'b0;
        n_chk++; if (got.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (i >= got.size()) begin n_fail++; $display("FAIL bp_order[%0d]: missing want %h", i, vals[i]); end
            else if (got[i] !== vals[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], vals[i]); end
        end
    endtask

    task automatic test_flush();
        // Fill both entries, then flush with an offered entry E.
        out_ready = 1'b0; in_sel = 2'd0;
        in_valid = 1'b1; in_data = {64'h0, 32'h0000A001}; step();
        in_valid = 1'b1; in_data = {64'h0, 32'h0000A002}; step();
        flush = 1'b1; in_valid = 1'b1; in_data = {64'h0, 32'h0000EEEE}; step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush2_valid: got %b want 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush2_in_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush2_stale[%0d]: valid %b data %h want 0", i, out_valid, out_data); end
        end
        // One entry held, flush with an accepted input and the head being consumed.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = {64'h0, 32'h0000B001}; step();
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = {64'h0, 32'h0000EEE1};
        n_chk++; if (out_valid !== 1'b1 || out_data !== 32'h0000B001) begin n_fail++;
            $display("FAIL flush1_head: valid %b data %h want 1 0000b001", out_valid, out_data); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush1_valid: got %b want 0", out_valid); end
        step();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush1_stale: valid %b data %h want 0", out_valid, out_data); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0; in_sel = 2'd3;
        in_valid = 1'b1; in_data = {64'h0, 32'h0000C001}; step();
        in_sel = 2'd1;
        in_valid = 1'b1; in_data = {32'h0, 32'h0000C002, 32'h0}; step();
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; step();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b want 0", out_valid); end
        n_chk++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL mrst_err: got %b want 0", out_err); end
        n_chk++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL mrst_data: got %h want 0", out_data); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_in_ready: got %b want 1", in_ready); end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_stale[%0d]: valid %b data %h want 0", i, out_valid, out_data); end
        end
    endtask

    task automatic test_random();
        logic [32:0] q [$];
        logic [32:0] e;
        int accepted;
        int cyc;
        logic m_in, m_out;
        accepted = 0;
        cyc = 0;
        while (accepted < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = {$urandom, $urandom, $urandom};
            m_out = (q.size() > 0) && out_ready;
            m_in  = in_valid && (q.size() < 2);
            if (flush) begin
                q.delete();
            end else begin
                if (m_out) void'(q.pop_front());
                if (m_in) begin
                    q.push_back(ref_entry(in_data, in_sel));
                    accepted++;
                end
            end
            step();
            cyc++;
            n_chk++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc %0d: valid %b in_ready %b want valid %b in_ready %b",
                         cyc, out_valid, in_ready, q.size() > 0, q.size() < 2);
            end else if (q.size() > 0) begin
                e = q[0];
                if ({out_err, out_data} !== e) begin
                    n_fail++;
                    $display("FAIL rand_data cyc %0d: got err %b data %h want err %b data %h",
                             cyc, out_err, out_data, e[32], e[31:0]);
                end
            end
        end
        flush = 1'b0;
        n_chk++;
        if (accepted < 1000) begin n_fail++; $display("FAIL rand_budget: accepted %0d want 1000", accepted); end
    endtask

    task automatic test_back_to_back();
        drain();
        in_sel = 2'd0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data = {64'h0, 32'(32'h100 + i)};
            step();
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== 32'(32'h100 + i) || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b[%0d]: valid %b data %h in_ready %b want 1 %h 1",
                         i, out_valid, out_data, in_ready, 32'(32'h100 + i));
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sel = 2'd0; in_data = '0;
        test_reset();
        test_pass_through();
        test_out_of_range();
        drain();
        test_back_pressure();
        drain();
        test_flush();
        drain();
        test_mid_reset();
        drain();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
